vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Raster timing generator and pixel sink for the VGA output path, running in the 108 MHz pixel clock domain from the PLL (1280x1024@60 defaults).
- Consumes the PLL `locked` indication and starts timing only after lock has been stable for a settle period.
- Pulls pixels from an upstream valid/ready stream during active video and drives registered HS/VS/DE/RGB to the DAC pins.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- HS_POL, 1, asserted level of vga_hs
- VS_POL, 1, asserted level of vga_vs
- DATA_W, 24, pixel width (RGB 8:8:8)
- LOCK_WAIT, 1024, clocks `locked` must stay high before timing starts

Ports:
- clk  in  1  pixel clock, PLL outclk_0
- rst  in  1  synchronous reset, active-high
- locked  in  1  PLL lock, asynchronous to clk
- in_data  in  DATA_W  pixel data
- in_valid  in  1  pixel data valid
- in_ready  out  1  sink ready; a pixel is consumed when in_valid & in_ready
- underflow_clr  in  1  clears the sticky underflow flag
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  active-video enable
- vga_rgb  out  DATA_W  pixel to DAC
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame
- underflow  out  1  sticky: in_ready was high while in_valid was low

Behaviour:
- `locked` passes through a 2-flop synchronizer (`lk_s`) before any use.
- FSM states:
  - WAIT_LOCK: go to SETTLE when lk_s=1.
  - SETTLE: counter runs 0..LOCK_WAIT-1. Go to RUN at the terminal count. Go back to WAIT_LOCK if lk_s=0.
  - RUN: go to WAIT_LOCK the same cycle lk_s=0.
- Entering RUN loads h=0, v=0. Outside RUN, h and v are held at 0.
- Counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v increments only when h wraps, and itself wraps at V_TOTAL-1.
  - Counter widths are clog2 of the totals.
- Region decode, all computed from (h,v):
  - act = RUN & h<H_ACTIVE & v<V_ACTIVE.
  - hs_on = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_on = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. It changes only at h=0.
- in_ready = act. This path is combinational from registered counters and state only; it never depends on in_valid.
- Output registers (latency 1 clock from the counter position):
  - vga_de <= act.
  - vga_hs <= hs_on ? HS_POL : ~HS_POL.
  - vga_vs <= vs_on ? VS_POL : ~VS_POL.
  - vga_rgb <= act & in_valid ? in_data : 0.
  - frame_start <= act & h==0 & v==0.
- Underflow: set on act & ~in_valid (that pixel is output as 0). Cleared by underflow_clr. If set and clear occur in the same cycle, set wins.
- Outside RUN, all outputs hold their idle values: de=0, rgb=0, hs=~HS_POL, vs=~VS_POL, frame_start=0, in_ready=0.
- A lock loss mid-line or mid-frame goes idle on the next clock. Timing restarts from h=0,v=0 only after a full SETTLE.
- Reset values: state WAIT_LOCK, all counters 0, synchronizer flops 0, outputs idle, underflow=0. Reset mid-frame behaves identically.
- The block does not stall the raster. Upstream must sustain one pixel per clock during active video.

Decomposition:
- Shared package `vga_pkg`:
  - the FSM state enum (WAIT_LOCK, SETTLE, RUN);
  - default 1280x1024@60 timing constants;
  - H_TOTAL and V_TOTAL derivation functions.
- One sub-module, `vga_sync_cnt`: h/v counters plus region decode (act, hs_on, vs_on, first-pixel). The top level holds the synchronizer, the FSM, the stream handshake and the output registers.

Test Plan (small timing: H 8/2/2/2, V 4/1/1/1, LOCK_WAIT=5, polarities 1):
- locked rises at t0 -> vga_de stays 0 and in_ready=0 until 2 sync clocks + 5 settle clocks have elapsed. After that, in_ready goes 1 and frame_start pulses once, one clock after in_ready rises.
- Continuous in_valid with in_data=row*16+col -> vga_rgb matches the value 1 clock after acceptance. Exactly 8 de-high clocks per active line, 4 active lines per frame, 14-clock lines, 7-line frame.
- Sync position check -> vga_hs high for exactly 2 clocks starting 2 clocks after de falls. vga_vs high for exactly 14 clocks, beginning at line 5.
- in_valid=0 for one active cycle -> that vga_rgb=0 and underflow=1 and stays 1. underflow_clr pulse -> returns to 0. Clear in the same cycle as a new underflow -> stays 1.
- locked drops mid-line 2 -> outputs idle within 1 clock + synchronizer delay. After relock and 5 settle clocks, the frame restarts at h=0,v=0 with frame_start.
- locked glitches low for 1 clock during SETTLE -> settle restarts; RUN is entered only after 5 consecutive locked clocks.
- rst asserted mid-frame -> all outputs idle the next clock, state WAIT_LOCK.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state type, default 1280x1024@60 timing and size helpers
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_e;

    localparam int DEF_H_ACTIVE  = 1280;
    localparam int DEF_H_FP      = 48;
    localparam int DEF_H_SYNC    = 112;
    localparam int DEF_H_BP      = 248;
    localparam int DEF_V_ACTIVE  = 1024;
    localparam int DEF_V_FP      = 1;
    localparam int DEF_V_SYNC    = 3;
    localparam int DEF_V_BP      = 38;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_LOCK_WAIT = 1024;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// rtl/vga_sync_cnt.sv - raster h/v counters and region decode, cleared while not running
module vga_sync_cnt
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic act,
    output logic hs_on,
    output logic vs_on,
    output logic first_px
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Holding both counters at zero outside RUN makes entry to RUN start at the frame origin.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        act      = run && (h_q < H_ACT) && (v_q < V_ACT);
        hs_on    = run && (h_q >= HS_BEG) && (h_q < HS_END);
        vs_on    = run && (v_q >= VS_BEG) && (v_q < VS_END);
        first_px = act && (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - PLL-lock gated VGA raster generator and pixel sink
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              underflow_clr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [DATA_W-1:0] vga_rgb,
    output logic              frame_start,
    output logic              underflow
);

    localparam int            LW         = cnt_w(LOCK_WAIT);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_WAIT - 1);
    localparam logic          HS_ASSERT  = 1'(HS_POL);
    localparam logic          VS_ASSERT  = 1'(VS_POL);

    logic              sync1_q, sync1_d;
    logic              lk_s_q, lk_s_d;
    vga_state_e        state_q, state_d;
    logic [LW-1:0]     settle_q, settle_d;
    logic              de_q, de_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [DATA_W-1:0] rgb_q, rgb_d;
    logic              fs_q, fs_d;
    logic              uf_q, uf_d;

    logic run, act, hs_on, vs_on, first_px;

    assign run = (state_q == RUN);

    vga_sync_cnt #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .act      (act),
        .hs_on    (hs_on),
        .vs_on    (vs_on),
        .first_px (first_px)
    );

    // Settle counter only advances on consecutive synchronized-lock cycles.
    always_comb begin
        sync1_d  = locked;
        lk_s_d   = sync1_q;
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            WAIT_LOCK: if (lk_s_q) state_d = SETTLE;
            SETTLE: begin
                if (!lk_s_q)                    state_d = WAIT_LOCK;
                else if (settle_q == LOCK_LAST) state_d = RUN;
                else                            settle_d = settle_q + LW'(1);
            end
            RUN:       if (!lk_s_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        de_d  = act;
        hs_d  = hs_on ? HS_ASSERT : ~HS_ASSERT;
        vs_d  = vs_on ? VS_ASSERT : ~VS_ASSERT;
        rgb_d = (act && in_valid) ? in_data : '0;
        fs_d  = first_px;
        uf_d  = (act && !in_valid) || (uf_q && !underflow_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lk_s_q   <= 1'b0;
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            de_q     <= 1'b0;
            hs_q     <= ~HS_ASSERT;
            vs_q     <= ~VS_ASSERT;
            rgb_q    <= '0;
            fs_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            lk_s_q   <= lk_s_d;
            state_q  <= state_d;
            settle_q <= settle_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            rgb_q    <= rgb_d;
            fs_q     <= fs_d;
            uf_q     <= uf_d;
        end
    end

    assign in_ready    = act;
    assign vga_de      = de_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule
